conv_frame_ingress: RTL and testbench
=====================================

// Module: conv_frame_ingress
// PURPOSE
//  AXI-Stream ingress stage directly upstream of the 3x3 convolution (Gauss/Sobel) stages.
//  Buffers incoming packed-pixel beats, locks onto frame start (tuser), checks line framing
//  (tlast), and presents one beat per cycle on inp_frame with the stall-based interface
//  the conv stages consume: a beat transfers only in cycles where stall==0.
// PARAMETERS
//  PIXELS_PER_BEAT  16                  pixels (8 bit each) per beat
//  IMAGE_DIM        512                 image width = height, in pixels
//  DATA_WIDTH       8*PIXELS_PER_BEAT   beat width
//  FIFO_DEPTH       4                   buffered beats; power of 2, >=2
// PORTS
//  clk         in   1           clock, all logic on rising edge
//  areset      in   1           asynchronous, active-high reset
//  s_tdata     in   DATA_WIDTH  pixel beat, pixel 0 in MSB byte
//  s_tvalid    in   1           beat valid
//  s_tready    out  1           ingress can accept a beat
//  s_tuser     in   1           start of frame, first beat of row 0
//  s_tlast     in   1           end of line, last beat of each row
//  dn_ready    in   1           downstream conv chain can take a beat this cycle
//  inp_frame   out  DATA_WIDTH  beat to conv stage; held stable while stall==1
//  stall       out  1           1 = no transfer this cycle; conv stages freeze
//  frame_done  out  1           1-cycle pulse when last beat of a frame transfers out
//  err_sof     out  1           sticky: tuser seen mid-frame
//  err_eol     out  1           sticky: tlast missing at line end or present mid-line
//  err_clr     in   1           synchronous clear of err_sof/err_eol
// BEHAVIOUR
//  Reset: s_tready=0, stall=1, inp_frame=0, frame_done=0, err_*=0, FIFO empty, state=WAIT_SOF.
//   s_tready rises on the 1st clk edge after areset deasserts.
//  Constants: COLS = IMAGE_DIM/PIXELS_PER_BEAT beats/row; ROWS = IMAGE_DIM rows.
//  Input accept: s_tready = ~fifo_full (registered count, no comb path from dn_ready).
//   Beat accepted when s_tvalid & s_tready.
//  States:
//   WAIT_SOF: accepted beats with s_tuser=0 are discarded (not pushed).
//             Beat with s_tuser=1 is pushed; col=1, row=0, state->ACTIVE.
//   ACTIVE:   every accepted beat is pushed; col increments, wraps at COLS with row+1.
//    - s_tuser=1 mid-frame: err_sof<=1, beat is pushed as new frame start, col=1, row=0.
//    - s_tlast must equal (col==COLS-1); mismatch sets err_eol. Counters follow col only,
//      never tlast.
//    - Push of beat col=COLS-1, row=ROWS-1: tagged end-of-frame, state->WAIT_SOF.
//  FIFO entry = {eof_tag, data}. Same-cycle push and pop is allowed at any occupancy, incl. full.
//  Output: pop = ~fifo_empty & dn_ready; stall = ~pop (combinational).
//   inp_frame = FIFO head data, 0 when empty.
//   frame_done = registered pop & eof_tag, so it pulses 1 cycle after the transfer.
//  Latency: a beat accepted at edge N is visible on inp_frame after edge N and transfers
//   in the first cycle with dn_ready=1 (min 1 cycle), preserving order.
//  Throughput: 1 beat/cycle sustained when s_tvalid=dn_ready=1.
//  err_clr: clears both flags in that cycle; a new error in the same cycle wins (flag stays 1).
//  areset mid-frame: FIFO flushed, counters 0, WAIT_SOF. The partial frame is lost and
//   frame_done is not raised for it.
// CONFIGURATION
//  CONV_INGRESS_STATS_EN defined: adds outputs frame_cnt[15:0] (increments on frame_done,
//   wraps 0xFFFF->0) and drop_cnt[15:0] (increments per beat discarded in WAIT_SOF,
//   saturates at 0xFFFF). Both reset to 0 and are not cleared by err_clr.
//  Not defined: those ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1. Reset, then a full frame (COLS*ROWS beats, correct tuser/tlast), dn_ready=1:
//     all beats out in order, stall=0 each transfer cycle, exactly one frame_done, err_*=0.
//  2. Same frame with dn_ready toggling 1-of-3 cycles: FIFO fills, s_tready=0 when 4 beats
//     held, inp_frame stable while stall=1, no loss or duplication.
//  3. 5 beats with tuser=0 before SOF: none appear on inp_frame; with STATS_EN drop_cnt=5.
//  4. tlast on col 3 of row 0 -> err_eol=1 and stays 1; err_clr pulse -> 0 next cycle.
//     tuser at row 2 col 5 -> err_sof=1 and the frame restarts counting from that beat.
//  5. areset asserted while 3 beats are buffered: stall=1, inp_frame=0 immediately.
//     After release, the next SOF frame completes normally with one frame_done.

Source files
------------

// File: rtl/conv_frame_ingress_if.sv
// Stream-side bundle for conv_frame_ingress: AXI-Stream input, stall-based
// output toward the conv chain, and the error/status handshake.
interface conv_frame_ingress_if #(
    parameter int DATA_WIDTH = 128
);
    logic [DATA_WIDTH-1:0] s_tdata;
    logic                  s_tvalid;
    logic                  s_tready;
    logic                  s_tuser;
    logic                  s_tlast;
    logic                  dn_ready;
    logic [DATA_WIDTH-1:0] inp_frame;
    logic                  stall;
    logic                  frame_done;
    logic                  err_sof;
    logic                  err_eol;
    logic                  err_clr;

    // Upstream source + downstream consumer side (the environment)
    modport master (
        output s_tdata, s_tvalid, s_tuser, s_tlast, dn_ready, err_clr,
        input  s_tready, inp_frame, stall, frame_done, err_sof, err_eol
    );

    // The ingress block itself
    modport slave (
        input  s_tdata, s_tvalid, s_tuser, s_tlast, dn_ready, err_clr,
        output s_tready, inp_frame, stall, frame_done, err_sof, err_eol
    );
endinterface

// File: rtl/conv_frame_ingress.sv
// conv_frame_ingress: AXI-Stream ingress ahead of the 3x3 conv stages.
// Locks onto frame start (tuser), checks line framing (tlast), buffers beats
// in a small FIFO and presents them with a stall-based interface.
// Optional build macro CONV_INGRESS_STATS_EN adds frame_cnt/drop_cnt outputs.
module conv_frame_ingress #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int IMAGE_DIM       = 512,
    parameter int DATA_WIDTH      = 8 * PIXELS_PER_BEAT,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                clk,
    input  logic                areset,
    conv_frame_ingress_if.slave bus
`ifdef CONV_INGRESS_STATS_EN
    ,
    output logic [15:0]         frame_cnt,
    output logic [15:0]         drop_cnt
`endif
);
    localparam int COLS = IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int ROWS = IMAGE_DIM;
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    typedef enum logic {S_WAIT_SOF = 1'b0, S_ACTIVE = 1'b1} state_t;

    state_t              r_state, w_state_nxt;
    logic [CW-1:0]       r_col, w_pos_col, w_col_nxt;
    logic [RW-1:0]       r_row, w_pos_row, w_row_nxt;
    logic                w_accept, w_push, w_pop, w_drop, w_eof;
    logic                w_set_sof, w_set_eol, w_full, w_empty;
    logic [DATA_WIDTH:0] r_mem [FIFO_DEPTH];
    logic [DATA_WIDTH:0] w_head;
    logic [AW-1:0]       r_wptr, r_rptr;
    logic [AW:0]         r_count;
    logic                r_rdy_en, r_frame_done, r_err_sof, r_err_eol;

    // Input side: ready only depends on registered occupancy, never on dn_ready
    assign w_full         = (r_count == CNT_FULL);
    assign w_empty        = (r_count == '0);
    assign bus.s_tready   = r_rdy_en & ~w_full;
    assign w_accept       = bus.s_tvalid & bus.s_tready;

    // A tuser beat always sits at (0,0); otherwise it takes the running position
    assign w_pos_col = bus.s_tuser ? '0 : r_col;
    assign w_pos_row = bus.s_tuser ? '0 : r_row;
    assign w_eof     = (w_pos_col == COL_LAST) && (w_pos_row == ROW_LAST);

    // Ready is held low until the first edge after reset release
    always_ff @(posedge clk or posedge areset) begin
        if (areset) r_rdy_en <= 1'b0;
        else        r_rdy_en <= 1'b1;
    end

    // FSM state register
    always_ff @(posedge clk or posedge areset) begin
        if (areset) r_state <= S_WAIT_SOF;
        else        r_state <= w_state_nxt;
    end

    // FSM next state: lock on tuser, drop back after the last beat of the frame
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WAIT_SOF: if (w_accept && bus.s_tuser) w_state_nxt = S_ACTIVE;
            S_ACTIVE:   if (w_accept && w_eof)       w_state_nxt = S_WAIT_SOF;
            default:    w_state_nxt = S_WAIT_SOF;
        endcase
        // A one-beat frame would finish on its own start beat
        if (r_state == S_WAIT_SOF && w_accept && bus.s_tuser && w_eof)
            w_state_nxt = S_WAIT_SOF;
    end

    // FSM outputs: push/drop decisions, error strobes, next beat position
    always_comb begin
        w_push    = 1'b0;
        w_drop    = 1'b0;
        w_set_sof = 1'b0;
        w_set_eol = 1'b0;
        case (r_state)
            S_WAIT_SOF: begin
                w_push = w_accept & bus.s_tuser;
                w_drop = w_accept & ~bus.s_tuser;
            end
            S_ACTIVE: begin
                w_push    = w_accept;
                w_set_sof = w_accept & bus.s_tuser;
                w_set_eol = w_accept & (bus.s_tlast != (w_pos_col == COL_LAST));
            end
            default: ;
        endcase
        if (w_eof) begin
            w_col_nxt = '0;
            w_row_nxt = '0;
        end else if (w_pos_col == COL_LAST) begin
            w_col_nxt = '0;
            w_row_nxt = w_pos_row + RW'(1);
        end else begin
            w_col_nxt = w_pos_col + CW'(1);
            w_row_nxt = w_pos_row;
        end
    end

    // Beat position counters advance on every pushed beat, independent of tlast
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_push) begin
            r_col <= w_col_nxt;
            r_row <= w_row_nxt;
        end
    end

    // FIFO storage: {eof_tag, data}; contents need no reset, occupancy does
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {w_eof, bus.s_tdata};
    end

    assign w_head        = r_mem[r_rptr];
    assign w_pop         = ~w_empty & bus.dn_ready;
    assign bus.stall     = ~w_pop;
    assign bus.inp_frame = w_empty ? '0 : w_head[DATA_WIDTH-1:0];

    // FIFO pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // frame_done pulses the cycle after the tagged last beat leaves
    always_ff @(posedge clk or posedge areset) begin
        if (areset) r_frame_done <= 1'b0;
        else        r_frame_done <= w_pop & w_head[DATA_WIDTH];
    end
    assign bus.frame_done = r_frame_done;

    // Sticky framing errors; a fresh error outranks a same-cycle clear
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_err_sof <= 1'b0;
            r_err_eol <= 1'b0;
        end else begin
            r_err_sof <= (r_err_sof & ~bus.err_clr) | w_set_sof;
            r_err_eol <= (r_err_eol & ~bus.err_clr) | w_set_eol;
        end
    end
    assign bus.err_sof = r_err_sof;
    assign bus.err_eol = r_err_eol;

`ifdef CONV_INGRESS_STATS_EN
    logic [15:0] r_frame_cnt, r_drop_cnt;

    // Frames completed (wrapping) and pre-SOF beats discarded (saturating)
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
        end else begin
            if (r_frame_done)                  r_frame_cnt <= r_frame_cnt + 16'd1;
            if (w_drop && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end
    assign frame_cnt = r_frame_cnt;
    assign drop_cnt  = r_drop_cnt;
`else
    // Discard count only feeds the optional statistics
    logic w_drop_unused;
    assign w_drop_unused = w_drop;
`endif
endmodule

// File: tb/tb_conv_frame_ingress.sv
// Directed bench for conv_frame_ingress with a reduced image (16x16, 2 px/beat)
// so whole frames stay short. Scoreboard queue holds expected {eof, data}.
module tb_conv_frame_ingress;
    localparam int PPB   = 2;
    localparam int DIM   = 16;
    localparam int DW    = 8 * PPB;
    localparam int DEPTH = 4;
    localparam int COLS  = DIM / PPB;
    localparam int FRAME = COLS * DIM;

    logic clk = 1'b0;
    logic areset;
    conv_frame_ingress_if #(.DATA_WIDTH(DW)) bus();
`ifdef CONV_INGRESS_STATS_EN
    logic [15:0] frame_cnt, drop_cnt;
`endif

    conv_frame_ingress #(
        .PIXELS_PER_BEAT(PPB), .IMAGE_DIM(DIM), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .areset(areset), .bus(bus.slave)
`ifdef CONV_INGRESS_STATS_EN
        , .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [DW:0]   exp_q[$];
    logic [DW:0]   mon_e;
    int            dn_mode = 0;
    int            dn_ph = 0;
    int            fd_cnt = 0;
    int            xfer_cnt = 0;
    int            cyc = 0;
    logic          exp_fd = 1'b0;
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(posedge clk) cyc++;

    // Downstream readiness pattern: 0 always, 1 one-of-three, 2 never
    always @(posedge clk) begin
        #2;
        dn_ph = (dn_ph == 2) ? 0 : dn_ph + 1;
        case (dn_mode)
            0:       bus.dn_ready = 1'b1;
            1:       bus.dn_ready = (dn_ph == 0);
            default: bus.dn_ready = 1'b0;
        endcase
    end

    // Output monitor: order, stability under stall, frame_done timing
    always @(negedge clk) begin
        if (areset) begin
            prev_hold = 1'b0;
            exp_fd    = 1'b0;
        end else begin
            chk("frame_done", 32'(bus.frame_done), 32'(exp_fd));
            if (bus.frame_done) fd_cnt++;
            exp_fd = 1'b0;
            if (!bus.stall) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_xfer", 32'(bus.stall), 32'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("data", 32'(bus.inp_frame), 32'(mon_e[DW-1:0]));
                    exp_fd = mon_e[DW];
                    xfer_cnt++;
                end
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) chk("hold", 32'(bus.inp_frame), 32'(prev_data));
                prev_hold = (bus.inp_frame != '0);
                prev_data = bus.inp_frame;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat is taken
    task automatic send_beat(input logic [DW-1:0] d, input logic user, input logic last,
                             input logic keep, input logic eof);
        int  t = 0;
        logic done = 1'b0;
        bus.s_tdata  = d;
        bus.s_tuser  = user;
        bus.s_tlast  = last;
        bus.s_tvalid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (bus.s_tready) begin
                done = 1'b1;
                if (keep) exp_q.push_back({eof, d});
            end else if (++t > 200) begin
                chk("tready_timeout", 32'(bus.s_tready), 32'd1);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        bus.s_tvalid = 1'b0;
        bus.s_tuser  = 1'b0;
        bus.s_tlast  = 1'b0;
    endtask

    // Beats first..last of a frame; bad marks one beat with inverted tlast
    task automatic send_range(input logic [DW-1:0] base, input int first, input int last,
                              input int bad);
        for (int i = first; i <= last; i++) begin
            send_beat(base + DW'(i), (i == 0), ((i % COLS) == COLS - 1) ^ (i == bad),
                      1'b1, (i == FRAME - 1));
        end
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int fd0, x0, c0;
        areset       = 1'b1;
        bus.s_tdata  = '0;
        bus.s_tvalid = 1'b0;
        bus.s_tuser  = 1'b0;
        bus.s_tlast  = 1'b0;
        bus.err_clr  = 1'b0;
        bus.dn_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_tready",   32'(bus.s_tready),   32'd0);
        chk("rst_stall",    32'(bus.stall),      32'd1);
        chk("rst_inp",      32'(bus.inp_frame),  32'd0);
        chk("rst_fdone",    32'(bus.frame_done), 32'd0);
        chk("rst_err_sof",  32'(bus.err_sof),    32'd0);
        chk("rst_err_eol",  32'(bus.err_eol),    32'd0);
        #2 areset = 1'b0;
        #1 chk("tready_before_edge", 32'(bus.s_tready), 32'd0);
        @(posedge clk); #1;
        chk("tready_after_edge", 32'(bus.s_tready), 32'd1);

        // 1: full frame, downstream always ready, one beat per cycle
        dn_mode = 0; fd0 = fd_cnt; x0 = xfer_cnt; c0 = cyc;
        send_range(16'h0100, 0, FRAME - 1, -1);
        chk("t1_throughput", 32'(cyc - c0), 32'(FRAME));
        wait_drain();
        chk("t1_frame_done", 32'(fd_cnt - fd0), 32'd1);
        chk("t1_xfers",      32'(xfer_cnt - x0), 32'(FRAME));
        chk("t1_err_sof",    32'(bus.err_sof), 32'd0);
        chk("t1_err_eol",    32'(bus.err_eol), 32'd0);

        // 2: fill the FIFO, then drain with dn_ready one cycle in three
        dn_mode = 2; fd0 = fd_cnt; x0 = xfer_cnt;
        send_range(16'h1100, 0, 3, -1);
        @(negedge clk);
        chk("t2_full_tready", 32'(bus.s_tready),  32'd0);
        chk("t2_full_stall",  32'(bus.stall),     32'd1);
        chk("t2_full_head",   32'(bus.inp_frame), 32'h1100);
        @(posedge clk); #1;
        dn_mode = 1;
        send_range(16'h1100, 4, FRAME - 1, -1);
        wait_drain();
        chk("t2_frame_done", 32'(fd_cnt - fd0), 32'd1);
        chk("t2_xfers",      32'(xfer_cnt - x0), 32'(FRAME));
        chk("t2_err_eol",    32'(bus.err_eol), 32'd0);

        // 3: beats before any SOF are discarded
        dn_mode = 0; x0 = xfer_cnt;
        for (int i = 0; i < 5; i++) send_beat(16'hDD00 + 16'(i), 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        chk("t3_stall",   32'(bus.stall),     32'd1);
        chk("t3_inp",     32'(bus.inp_frame), 32'd0);
        chk("t3_xfers",   32'(xfer_cnt - x0), 32'd0);
        chk("t3_err_eol", 32'(bus.err_eol),   32'd0);
`ifdef CONV_INGRESS_STATS_EN
        chk("t3_drop_cnt",  32'(drop_cnt),  32'd5);
        chk("t3_frame_cnt", 32'(frame_cnt), 32'd2);
`endif
        @(posedge clk); #1;

        // 4: bad tlast on row 0 col 3, sticky until cleared; tuser at row 2 col 5
        fd0 = fd_cnt; x0 = xfer_cnt;
        send_range(16'h3000, 0, 3, 3);
        @(negedge clk);
        chk("t4_eol_set", 32'(bus.err_eol), 32'd1);
        @(posedge clk); #1;
        send_range(16'h3000, 4, 2 * COLS + 4, -1);
        @(negedge clk);
        chk("t4_eol_sticky", 32'(bus.err_eol), 32'd1);
        chk("t4_sof_clean",  32'(bus.err_sof), 32'd0);
        @(posedge clk); #1;
        bus.err_clr = 1'b1;
        @(posedge clk); #1;
        bus.err_clr = 1'b0;
        @(negedge clk);
        chk("t4_eol_cleared", 32'(bus.err_eol), 32'd0);
        @(posedge clk); #1;
        send_range(16'h4000, 0, FRAME - 1, -1);
        wait_drain();
        chk("t4_err_sof",    32'(bus.err_sof), 32'd1);
        chk("t4_err_eol",    32'(bus.err_eol), 32'd0);
        chk("t4_frame_done", 32'(fd_cnt - fd0), 32'd1);
        chk("t4_xfers",      32'(xfer_cnt - x0), 32'(2 * COLS + 5 + FRAME));
        bus.err_clr = 1'b1;
        @(posedge clk); #1;
        bus.err_clr = 1'b0;
        @(negedge clk);
        chk("t4_sof_cleared", 32'(bus.err_sof), 32'd0);
        @(posedge clk); #1;

        // 5: reset with 3 beats buffered, then a clean frame
        dn_mode = 2; fd0 = fd_cnt;
        send_range(16'h5000, 0, 2, -1);
        @(negedge clk);
        chk("t5_head", 32'(bus.inp_frame), 32'h5000);
        @(posedge clk); #1;
        areset = 1'b1;
        #1;
        chk("t5_rst_stall",  32'(bus.stall),     32'd1);
        chk("t5_rst_inp",    32'(bus.inp_frame), 32'd0);
        chk("t5_rst_tready", 32'(bus.s_tready),  32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 areset = 1'b0;
        @(posedge clk); #1;
        dn_mode = 0; x0 = xfer_cnt;
        send_range(16'h6000, 0, FRAME - 1, -1);
        wait_drain();
        chk("t5_frame_done", 32'(fd_cnt - fd0), 32'd1);
        chk("t5_xfers",      32'(xfer_cnt - x0), 32'(FRAME));
        chk("t5_err_sof",    32'(bus.err_sof), 32'd0);
        chk("t5_err_eol",    32'(bus.err_eol), 32'd0);
`ifdef CONV_INGRESS_STATS_EN
        chk("t5_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("t5_drop_cnt",  32'(drop_cnt),  32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
